// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity helper and frame length.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    function automatic int unsigned frame_cycles(input int unsigned ticks,
                                                 input int unsigned parity_en,
                                                 input int unsigned stop_bits);
        return (9 + parity_en + stop_bits) * ticks;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..TicksPerBaud-1 while enabled, flags the last tick.
// Combinational last_o from the registered count; clr_i holds the count at zero.
module uart_baud_cnt #(
    parameter int unsigned TicksPerBaud = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam int unsigned      CntW   = $clog2(TicksPerBaud + 1);
    localparam logic [CntW-1:0]  CntMax = CntW'(TicksPerBaud - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign last_o = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with one-entry holding register; line falls one cycle after a byte lands in hold.
// tx_ready_o drops while the hold is full; strobes offered then are dropped, not stalled.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned TicksPerBaud = 3,
    parameter bit          ParityEn     = 1'b0,
    parameter bit          ParityOdd    = 1'b0,
    parameter int unsigned StopBits     = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_stb_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_busy_o,
    output logic       uart_tx_no
);

    localparam logic StopLast = 1'(StopBits - 1);

    tx_state_e  state_q;
    logic [7:0] shift_q;
    logic [7:0] hold_q;
    logic       hold_valid_q;
    logic       hold_valid_d;
    logic [2:0] bit_idx_q;
    logic       stop_idx_q;
    logic       parity_q;
    logic       tx_q;
    logic       baud_last;
    logic       accept;
    logic       start_frame;

    uart_baud_cnt #(
        .TicksPerBaud(TicksPerBaud)
    ) u_baud (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state_q == StIdle),
        .en_i  (1'b1),
        .last_o(baud_last)
    );

    assign accept = tx_stb_i && !hold_valid_q;

    // A pending byte is launched from idle, or chained straight out of the final stop tick.
    assign start_frame = hold_valid_q &&
                         ((state_q == StIdle) ||
                          (state_q == StStop && baud_last && stop_idx_q == StopLast));

    always_comb begin
        hold_valid_d = hold_valid_q;
        if (start_frame) begin
            hold_valid_d = 1'b0;
        end
        if (accept) begin
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            hold_valid_q <= hold_valid_d;
            if (accept) begin
                hold_q <= tx_data_i;
            end
            if (start_frame) begin
                shift_q  <= hold_q;
                parity_q <= parity_bit(hold_q, ParityOdd);
                tx_q     <= 1'b0;
                state_q  <= StStart;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        tx_q <= 1'b1;
                    end
                    StStart: begin
                        if (baud_last) begin
                            state_q   <= StData;
                            bit_idx_q <= '0;
                            tx_q      <= shift_q[0];
                        end
                    end
                    StData: begin
                        if (baud_last) begin
                            if (bit_idx_q == 3'd7) begin
                                if (ParityEn) begin
                                    state_q <= StParity;
                                    tx_q    <= parity_q;
                                end else begin
                                    state_q    <= StStop;
                                    stop_idx_q <= 1'b0;
                                    tx_q       <= 1'b1;
                                end
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                                tx_q      <= shift_q[bit_idx_q + 3'd1];
                            end
                        end
                    end
                    StParity: begin
                        if (baud_last) begin
                            state_q    <= StStop;
                            stop_idx_q <= 1'b0;
                            tx_q       <= 1'b1;
                        end
                    end
                    StStop: begin
                        if (baud_last) begin
                            if (stop_idx_q == StopLast) begin
                                state_q <= StIdle;
                            end else begin
                                stop_idx_q <= 1'b1;
                            end
                            tx_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx_ready_o = !hold_valid_q;
    assign tx_busy_o  = (state_q != StIdle) || hold_valid_q;
    assign uart_tx_no = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four differently parameterised instances checked cycle by cycle
// against a frame-level model, plus directed checks of the key timing cases.
module tb_uart_tx;

    localparam int NI = 4;

    function automatic int tpb(input int i);
        case (i)
            0: return 4;
            1: return 4;
            2: return 1;
            default: return 3;
        endcase
    endfunction
    function automatic int pen(input int i);   return (i == 1 || i == 3) ? 1 : 0; endfunction
    function automatic int podd(input int i);  return (i == 3) ? 1 : 0;           endfunction
    function automatic int nstop(input int i); return (i == 1 || i == 3) ? 2 : 1; endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic       stb  [NI];
    logic [7:0] dat  [NI];
    logic       rdy  [NI];
    logic       bsy  [NI];
    logic       line [NI];

    always #5 clk = ~clk;

    uart_tx #(.TicksPerBaud(4), .ParityEn(1'b0), .ParityOdd(1'b0), .StopBits(1)) u0 (
        .clk_i(clk), .rst_i(rst), .tx_stb_i(stb[0]), .tx_data_i(dat[0]),
        .tx_ready_o(rdy[0]), .tx_busy_o(bsy[0]), .uart_tx_no(line[0]));
    uart_tx #(.TicksPerBaud(4), .ParityEn(1'b1), .ParityOdd(1'b0), .StopBits(2)) u1 (
        .clk_i(clk), .rst_i(rst), .tx_stb_i(stb[1]), .tx_data_i(dat[1]),
        .tx_ready_o(rdy[1]), .tx_busy_o(bsy[1]), .uart_tx_no(line[1]));
    uart_tx #(.TicksPerBaud(1), .ParityEn(1'b0), .ParityOdd(1'b0), .StopBits(1)) u2 (
        .clk_i(clk), .rst_i(rst), .tx_stb_i(stb[2]), .tx_data_i(dat[2]),
        .tx_ready_o(rdy[2]), .tx_busy_o(bsy[2]), .uart_tx_no(line[2]));
    uart_tx #(.TicksPerBaud(3), .ParityEn(1'b1), .ParityOdd(1'b1), .StopBits(2)) u3 (
        .clk_i(clk), .rst_i(rst), .tx_stb_i(stb[3]), .tx_data_i(dat[3]),
        .tx_ready_o(rdy[3]), .tx_busy_o(bsy[3]), .uart_tx_no(line[3]));

    // Model: the line values still to be sent for the current frame, plus the hold slot.
    bit       m_bits [NI][48];
    int       m_pos  [NI];
    int       m_len  [NI];
    bit       m_hv   [NI];
    bit [7:0] m_hb   [NI];
    bit       e_line [NI];
    bit       e_rdy  [NI];
    bit       e_bsy  [NI];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic build_frame(input int i, input bit [7:0] b);
        bit seq [12];
        int nb;
        int n;
        seq[0] = 1'b0;
        for (int k = 0; k < 8; k++) seq[1 + k] = b[k];
        nb = 9;
        if (pen(i) == 1) begin
            // even parity makes the total count of ones even; odd makes it odd
            seq[nb] = (($countones(b) % 2) == 1) ? (podd(i) == 0) : (podd(i) == 1);
            nb++;
        end
        for (int s = 0; s < nstop(i); s++) begin
            seq[nb] = 1'b1;
            nb++;
        end
        n = 0;
        for (int s = 0; s < nb; s++) begin
            for (int t = 0; t < tpb(i); t++) begin
                m_bits[i][n] = seq[s];
                n++;
            end
        end
        m_len[i] = n;
        m_pos[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_pos[i] = 0; m_len[i] = 0; m_hv[i] = 0; m_hb[i] = 0;
            e_line[i] = 1; e_rdy[i] = 1; e_bsy[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit pre;
            bit in_frame;
            if (rst) begin
                m_pos[i] = 0; m_len[i] = 0; m_hv[i] = 0;
                e_line[i] = 1; e_rdy[i] = 1; e_bsy[i] = 0;
            end else begin
                pre = m_hv[i];
                if (m_pos[i] == m_len[i] && pre) begin
                    build_frame(i, m_hb[i]);
                    m_hv[i] = 0;
                end
                if (m_pos[i] < m_len[i]) begin
                    e_line[i] = m_bits[i][m_pos[i]];
                    m_pos[i]++;
                    in_frame = 1;
                end else begin
                    e_line[i] = 1;
                    in_frame = 0;
                end
                if (stb[i] && !pre) begin
                    m_hv[i] = 1;
                    m_hb[i] = dat[i];
                end
                e_rdy[i] = !m_hv[i];
                e_bsy[i] = in_frame || m_hv[i];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("line%0d", i), int'(line[i]), int'(e_line[i]));
                chk($sformatf("ready%0d", i), int'(rdy[i]), int'(e_rdy[i]));
                chk($sformatf("busy%0d", i), int'(bsy[i]), int'(e_bsy[i]));
            end
        end
    end

    // Returns #1 after the edge that accepts the byte.
    task automatic send(input int i, input bit [7:0] b);
        int w = 0;
        @(negedge clk);
        while (m_hv[i] && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("send_wait%0d", i), int'(w < 200), 1);
        stb[i] = 1'b1;
        dat[i] = b;
        @(posedge clk);
        #1 stb[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int w = 0;
        while ((m_pos[i] != m_len[i] || m_hv[i] || e_bsy[i]) && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("idle_wait%0d", i), int'(w < 300), 1);
    endtask

    // Busy is counted from the cycle the line falls; the hold-pending cycle before it is excluded.
    task automatic send_measure(input int i, input bit [7:0] b, input int exp_len,
                                input int par_pos, input int exp_par);
        int cnt = 0;
        send(i, b);
        @(negedge clk);
        chk($sformatf("lat_high%0d", i), int'(line[i]), 1);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k == 0) chk($sformatf("lat_low%0d", i), int'(line[i]), 0);
            if (k == par_pos) chk($sformatf("parity%0d", i), int'(line[i]), exp_par);
            if (bsy[i]) cnt++;
        end
        chk($sformatf("busy_len%0d", i), cnt, exp_len);
    endtask

    bit pat [10];
    int zeros;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            stb[i] = 1'b0;
            dat[i] = 8'h00;
        end
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_line", int'(line[0]), 1);
        chk("rst_ready", int'(rdy[0]), 1);
        chk("rst_busy", int'(bsy[0]), 0);
        rst = 1'b0;

        send_measure(0, 8'h55, 40, -1, 0);
        wait_idle(0);
        send_measure(1, 8'h07, 48, 36, 1);
        wait_idle(1);
        send_measure(3, 8'h07, 36, 27, 0);
        wait_idle(3);

        // Back-to-back bytes, then a strobe while the hold is full.
        send(0, 8'hA5);
        @(negedge clk);
        chk("rdy_pending", int'(rdy[0]), 0);
        @(negedge clk);
        chk("rdy_during", int'(rdy[0]), 1);
        send(0, 8'h3C);
        @(negedge clk);
        chk("rdy_second", int'(rdy[0]), 0);
        stb[0] = 1'b1;
        dat[0] = 8'hFF;
        @(posedge clk);
        #1 stb[0] = 1'b0;
        @(negedge clk);
        chk("rdy_full", int'(rdy[0]), 0);
        wait_idle(0);

        // Reset during data bit 3 of 0x00 with 0x99 waiting in hold.
        send(0, 8'h00);
        send(0, 8'h99);
        repeat (15) @(posedge clk);
        #1 chk("bit3_low", int'(line[0]), 0);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("abort_line", int'(line[0]), 1);
        chk("abort_ready", int'(rdy[0]), 1);
        chk("abort_busy", int'(bsy[0]), 0);
        rst = 1'b0;
        zeros = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!line[0]) zeros++;
        end
        chk("no_restart", zeros, 0);

        // One bit per clock, then an accept on the final stop tick.
        pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        send(2, 8'h81);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("fast_bit%0d", k), int'(line[2]), int'(pat[k]));
        end
        stb[2] = 1'b1;
        dat[2] = 8'h42;
        @(posedge clk);
        #1 stb[2] = 1'b0;
        @(negedge clk);
        chk("gap_high", int'(line[2]), 1);
        @(negedge clk);
        chk("gap_start", int'(line[2]), 0);
        wait_idle(2);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < NI; i++) begin
                stb[i] = ($urandom_range(0, 2) == 0);
                dat[i] = 8'($urandom);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) stb[i] = 1'b0;
        for (int i = 0; i < NI; i++) wait_idle(i);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
